// File: rtl/io_map_pkg.sv
// Shared I/O address map, display widths and controller state encoding
// for the memory-mapped I/O window that sits after the MEM stage.
package io_map_pkg;

   localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
   localparam logic [7:0]  SW_OFS  = 8'h70;
   localparam logic [7:0]  LED_OFS = 8'h60;
   localparam logic [7:0]  SEG_OFS = 8'h80;
   localparam logic [7:0]  CNT_OFS = 8'hA0;

   localparam int LED_W = 24;
   localparam int SEG_W = 32;
   localparam int SW_W  = 24;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_ENTER = 2'd1,
      RESP       = 2'd2
   } io_state_t;

endpackage

// File: rtl/io_cycle_counter.sv
// Free-running 32-bit cycle counter; reset loads INIT, otherwise +1 per
// clock with natural wrap at the top of the range.
module io_cycle_counter #(
   parameter logic [31:0] INIT = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] count
);

   always_ff @(posedge clock) begin
      if (reset)
         count <= INIT;
      else
         count <= count + 32'd1;
   end

endmodule

// File: rtl/mmio_io_ctrl.sv
// I/O window decoder: switch-read handshake (stall until enter), LED and
// seven-segment store latches, and a readable cycle counter.
module mmio_io_ctrl
   import io_map_pkg::*;
#(
   parameter logic [31:0] CNT_INIT = 32'h0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      mem_addr,
   input  logic             mem_re,
   input  logic             mem_we,
   input  logic [31:0]      mem_wdata,
   input  logic [SW_W-1:0]  switch,
   input  logic             enter,
   output logic             io_hit,
   output logic [31:0]      io_rdata,
   output logic             stall_req_io,
   output logic [LED_W-1:0] led_data,
   output logic [SEG_W-1:0] seg_data,
   output logic             blink_need
);

   io_state_t   state;
   io_state_t   next_state;
   logic [31:0] sw_buf;
   logic [31:0] cycle_cnt;
   logic [7:0]  ofs;
   logic        sw_rd;
   logic        cnt_rd;

   assign ofs    = mem_addr[7:0];
   assign io_hit = (mem_addr[31:8] == IO_BASE[31:8]);
   // A simultaneous store wins, so a combined access never starts a wait.
   assign sw_rd  = mem_re & ~mem_we & io_hit & (ofs == SW_OFS);
   assign cnt_rd = mem_re & io_hit & (ofs == CNT_OFS);

   io_cycle_counter #(
      .INIT (CNT_INIT)
   ) u_cycle_counter (
      .clock (clock),
      .reset (reset),
      .count (cycle_cnt)
   );

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Enter is only honoured once already waiting, so a press coincident with
   // the request does not satisfy it.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:       if (sw_rd) next_state = WAIT_ENTER;
         WAIT_ENTER: if (enter) next_state = RESP;
         RESP:       next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      stall_req_io = ((state == IDLE) & sw_rd) | (state == WAIT_ENTER);
      blink_need   = (state == WAIT_ENTER);
      if (state == RESP)
         io_rdata = sw_buf;
      else if (cnt_rd)
         io_rdata = cycle_cnt;
      else
         io_rdata = 32'h0;
   end

   always_ff @(posedge clock) begin
      if (reset)
         sw_buf <= 32'h0;
      else if ((state == WAIT_ENTER) && enter)
         sw_buf <= {8'h0, switch};
   end

   // Stores are accepted in every state, independent of the switch handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         led_data <= '0;
         seg_data <= '0;
      end else if (mem_we && io_hit) begin
         if (ofs == LED_OFS)
            led_data <= mem_wdata[LED_W-1:0];
         else if (ofs == SEG_OFS)
            seg_data <= mem_wdata[SEG_W-1:0];
      end
   end

endmodule
